// File: rtl/mult_seq_signed16x2_acc_pkg.sv
// Shared definitions for the radix-4 sequential signed multiplier.
// This covers the default width, the controller state encoding,
// the iteration count and the digit-select flag.
package mult_pkg;

   localparam int W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   // Selects the negative-weight form of the most significant digit
   localparam logic LAST_DIGIT = 1'b1;

   // One 2-bit digit of B is consumed per cycle
   function automatic int iter_count(input int w);
      return w / 2;
   endfunction

endpackage

// File: rtl/mult_seq_signed16x2_acc_pp_layer.sv
// Combinational partial-product layer: a times one 2-bit digit of B.
// For ordinary digits, the digit is the unsigned value 2*b_hi + b_lo.
// For the top digit, b_hi carries negative weight, so the digit is
// b_lo - 2*b_hi. The result is exact in W+2 signed bits.
module pp_layer_signed16x2_beh #(
   parameter int W = 16
) (
   input  logic signed [W-1:0] i_a,
   input  logic                i_b_lo,
   input  logic                i_b_hi,
   input  logic                i_last,
   output logic signed [W+1:0] o_pp
);

   logic signed [2:0]   w_digit;
   logic signed [W+1:0] w_a_ext;
   logic signed [W+1:0] w_digit_ext;

   // The digit is a 3-bit signed value in the range -2..3.
   // The top digit {b_hi,b_hi,b_lo} encodes 0, 1, -2 or -1.
   always_comb begin
      w_digit     = i_last ? {i_b_hi, i_b_hi, i_b_lo} : {1'b0, i_b_hi, i_b_lo};
      w_a_ext     = {{2{i_a[W-1]}}, i_a};
      w_digit_ext = {{(W-1){w_digit[2]}}, w_digit};
      o_pp        = w_a_ext * w_digit_ext;
   end

endmodule

// File: rtl/mult_seq_signed16x2_acc.sv
// Sequential signed W x W multiplier that consumes B two bits per cycle, LSB-first.
// Each layer product is added into the top of a shift-right accumulator,
// so after W/2 steps the low PW bits hold the exact product.
module mult_seq_signed16x2_acc
   import mult_pkg::*;
#(
   parameter int W  = W_DEFAULT,
   parameter int PW = 2 * W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_a,
   input  logic signed [W-1:0] in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PW-1:0]       out_p,
   output logic                busy
);

   localparam int ITER = iter_count(W);
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

   mult_state_t          r_state;
   logic signed [W-1:0]  r_a;
   logic [W-1:0]         r_b_sh;
   logic signed [PW+1:0] r_acc;
   logic [CW-1:0]        r_cnt;
   logic [PW-1:0]        r_p;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;

   logic                 w_last;
   logic signed [W+1:0]  w_pp;
   logic signed [PW+1:0] w_acc_sum;
   logic signed [PW+1:0] w_acc_sh;

   pp_layer_signed16x2_beh #(.W(W)) u_pp_layer (
      .i_a    (r_a),
      .i_b_lo (r_b_sh[0]),
      .i_b_hi (r_b_sh[1]),
      .i_last (w_last),
      .o_pp   (w_pp)
   );

   // The layer product enters at the top of the accumulator.
   // The two guard bits absorb any growth, and the result then drops one digit position.
   always_comb begin
      w_last    = (r_cnt == LAST_CNT) ? LAST_DIGIT : ~LAST_DIGIT;
      w_acc_sum = r_acc + $signed({w_pp, {W{1'b0}}});
      w_acc_sh  = w_acc_sum >>> 2;
   end

   // Controller with datapath registers; the handshake outputs are registered with the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b_sh      <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_p         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a        <= in_a;
                  r_b_sh     <= in_b;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            RUN: begin
               r_acc  <= w_acc_sh;
               r_b_sh <= r_b_sh >> 2;
               r_cnt  <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) begin
                  r_state     <= DONE;
                  r_p         <= w_acc_sh[PW-1:0];
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_p     = r_p;

endmodule
